dcache_miss_unit: RTL and testbench

- Initiator side of the cache-miss memory protocol, owned by the D$.
- Accepts per-thread line misses from the D$ and, when the victim line is dirty, first issues a writeback store, then a line load.
- Matches responses by cache_id/thread_id and returns the fill (or bus error) to the D$.
- Allows at most one outstanding transaction per thread, which the memory-side per-cache FIFO depth (THR_PER_CORE) requires.

---
 rtl/dcache_miss_unit.sv | 167 ++++++++++++++++
 tb/tb_dcache_miss_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_miss_unit                                                           |
// | D$ miss initiator: per-thread writeback + line load, response matching.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dcache_miss_unit #(
  parameter int         THR      = 4,
  parameter int         THR_W    = 2,
  parameter int         ADDR_W   = 32,
  parameter int         LINE_W   = 128,
  parameter logic       CACHE_ID = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             miss_valid,
  input  logic [THR_W-1:0]                 miss_thread,
  input  logic [ADDR_W-1:0]                miss_addr,
  input  logic                             miss_wb,
  input  logic [ADDR_W-1:0]                miss_wb_addr,
  input  logic [LINE_W-1:0]                miss_wb_data,
  output logic [THR-1:0]                   miss_ready,
  output logic                             dcache_req_valid_miss,
  output logic [ADDR_W+LINE_W+THR_W:0]     dcache_req_info_miss,
  input  logic                             rsp_valid_miss,
  input  logic                             rsp_cache_id,
  input  logic [THR_W-1:0]                 rsp_thread_id,
  input  logic                             rsp_bus_error,
  input  logic [LINE_W-1:0]                rsp_data_miss,
  output logic                             fill_valid,
  output logic [THR_W-1:0]                 fill_thread,
  output logic [ADDR_W-1:0]                fill_addr,
  output logic [LINE_W-1:0]                fill_data,
  output logic                             fill_error,
  output logic                             protocol_err
);

  localparam logic [2:0]       S_IDLE    = 3'd0;
  localparam logic [2:0]       S_WB_REQ  = 3'd1;
  localparam logic [2:0]       S_WB_WAIT = 3'd2;
  localparam logic [2:0]       S_LD_REQ  = 3'd3;
  localparam logic [2:0]       S_LD_WAIT = 3'd4;
  localparam logic [THR_W-1:0] c_rr_init = THR_W'(THR - 1);

  logic [2:0]        r_state     [THR];
  logic [2:0]        w_state_nxt [THR];
  logic [ADDR_W-1:0] r_addr      [THR];
  logic [ADDR_W-1:0] r_wb_addr   [THR];
  logic [LINE_W-1:0] r_wb_data   [THR];
  logic [THR_W-1:0]  r_rr_ptr;
  logic [THR_W-1:0]  w_gnt_idx;
  logic              w_gnt_valid;
  logic              w_req_store;
  logic [ADDR_W-1:0] w_req_addr;
  logic [LINE_W-1:0] w_req_data;
  logic              w_accept;
  logic              w_rsp_hit;
  logic              w_rsp_wait;
  logic              w_rsp_match;
  logic              w_fill_fire;
  logic              r_fill_valid;
  logic              r_fill_error;
  logic              r_protocol_err;
  logic [THR_W-1:0]  r_fill_thread;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [LINE_W-1:0] r_fill_data;

  assign w_accept    = miss_valid && (r_state[miss_thread] == S_IDLE);
  assign w_rsp_hit   = rsp_valid_miss && (rsp_cache_id == CACHE_ID);
  assign w_rsp_wait  = (r_state[rsp_thread_id] == S_WB_WAIT) ||
                       (r_state[rsp_thread_id] == S_LD_WAIT);
  assign w_rsp_match = w_rsp_hit && w_rsp_wait;
  // A failed writeback completes the miss with an error fill; the load is dropped.
  assign w_fill_fire = w_rsp_match &&
                       ((r_state[rsp_thread_id] == S_LD_WAIT) || rsp_bus_error);

  // Round-robin search starts one past the last granted slot.
  always_comb begin
    int w_idx;
    w_idx       = 0;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= THR; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % THR;
      if (!w_gnt_valid &&
          ((r_state[w_idx] == S_WB_REQ) || (r_state[w_idx] == S_LD_REQ))) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = THR_W'(w_idx);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < THR; i++) r_state[i] <= S_IDLE;
      r_rr_ptr <= c_rr_init;
    end else begin
      for (int i = 0; i < THR; i++) r_state[i] <= w_state_nxt[i];
      if (w_gnt_valid) r_rr_ptr <= w_gnt_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < THR; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE:
          if (w_accept && (int'(miss_thread) == i))
            w_state_nxt[i] = miss_wb ? S_WB_REQ : S_LD_REQ;
        S_WB_REQ:
          if (w_gnt_valid && (int'(w_gnt_idx) == i)) w_state_nxt[i] = S_WB_WAIT;
        S_WB_WAIT:
          if (w_rsp_match && (int'(rsp_thread_id) == i))
            w_state_nxt[i] = rsp_bus_error ? S_IDLE : S_LD_REQ;
        S_LD_REQ:
          if (w_gnt_valid && (int'(w_gnt_idx) == i)) w_state_nxt[i] = S_LD_WAIT;
        S_LD_WAIT:
          if (w_rsp_match && (int'(rsp_thread_id) == i)) w_state_nxt[i] = S_IDLE;
        default:
          w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < THR; i++) miss_ready[i] = (r_state[i] == S_IDLE);
    w_req_store           = (r_state[w_gnt_idx] == S_WB_REQ);
    w_req_addr            = w_req_store ? r_wb_addr[w_gnt_idx] : r_addr[w_gnt_idx];
    w_req_data            = w_req_store ? r_wb_data[w_gnt_idx] : LINE_W'(0);
    dcache_req_valid_miss = w_gnt_valid;
    dcache_req_info_miss  = {w_req_addr, w_req_store, w_req_data, w_gnt_idx};
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr[miss_thread]    <= miss_addr;
      r_wb_addr[miss_thread] <= miss_wb_addr;
      r_wb_data[miss_thread] <= miss_wb_data;
    end
    if (w_fill_fire) begin
      r_fill_thread <= rsp_thread_id;
      r_fill_addr   <= r_addr[rsp_thread_id];
      r_fill_data   <= rsp_data_miss;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fill_valid   <= 1'b0;
      r_fill_error   <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_fill_valid   <= w_fill_fire;
      r_fill_error   <= w_fill_fire && rsp_bus_error;
      r_protocol_err <= r_protocol_err || (w_rsp_hit && !w_rsp_wait);
    end
  end

  assign fill_valid   = r_fill_valid;
  assign fill_error   = r_fill_error;
  assign fill_thread  = r_fill_thread;
  assign fill_addr    = r_fill_addr;
  assign fill_data    = r_fill_data;
  assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_miss_unit                                                        |
// | Directed self-checking bench for dcache_miss_unit.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dcache_miss_unit;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miss_valid = 1'b0;
  logic [1:0]     miss_thread = '0;
  logic [31:0]    miss_addr = '0;
  logic           miss_wb = 1'b0;
  logic [31:0]    miss_wb_addr = '0;
  logic [127:0]   miss_wb_data = '0;
  logic [3:0]     miss_ready;
  logic           req_valid;
  logic [162:0]   req_info;
  logic           rsp_valid = 1'b0;
  logic           rsp_cache_id = 1'b0;
  logic [1:0]     rsp_thread = '0;
  logic           rsp_err = 1'b0;
  logic [127:0]   rsp_data = '0;
  logic           fill_valid;
  logic [1:0]     fill_thread;
  logic [31:0]    fill_addr;
  logic [127:0]   fill_data;
  logic           fill_error;
  logic           protocol_err;

  logic [31:0]    q_addr;
  logic           q_store;
  logic [127:0]   q_data;
  logic [1:0]     q_tid;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] c_beef = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] c_a5   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] c_d1   = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] c_d2   = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;

  assign q_addr  = req_info[162:131];
  assign q_store = req_info[130];
  assign q_data  = req_info[129:2];
  assign q_tid   = req_info[1:0];

  dcache_miss_unit dut (
    .clock                 (clk),
    .reset                 (rst),
    .miss_valid            (miss_valid),
    .miss_thread           (miss_thread),
    .miss_addr             (miss_addr),
    .miss_wb               (miss_wb),
    .miss_wb_addr          (miss_wb_addr),
    .miss_wb_data          (miss_wb_data),
    .miss_ready            (miss_ready),
    .dcache_req_valid_miss (req_valid),
    .dcache_req_info_miss  (req_info),
    .rsp_valid_miss        (rsp_valid),
    .rsp_cache_id          (rsp_cache_id),
    .rsp_thread_id         (rsp_thread),
    .rsp_bus_error         (rsp_err),
    .rsp_data_miss         (rsp_data),
    .fill_valid            (fill_valid),
    .fill_thread           (fill_thread),
    .fill_addr             (fill_addr),
    .fill_data             (fill_data),
    .fill_error            (fill_error),
    .protocol_err          (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then drop the single-cycle miss/response strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    rsp_valid  = 1'b0;
  endtask

  task automatic set_miss(input logic [1:0] t, input logic [31:0] a, input logic wb,
                          input logic [31:0] wa, input logic [127:0] wd);
    miss_valid   = 1'b1;
    miss_thread  = t;
    miss_addr    = a;
    miss_wb      = wb;
    miss_wb_addr = wa;
    miss_wb_data = wd;
  endtask

  task automatic set_rsp(input logic id, input logic [1:0] t, input logic err,
                         input logic [127:0] d);
    rsp_valid    = 1'b1;
    rsp_cache_id = id;
    rsp_thread   = t;
    rsp_err      = err;
    rsp_data     = d;
  endtask

  task automatic chk_req(input string tag, input logic [1:0] t, input logic st,
                         input logic [31:0] a, input logic [127:0] d);
    chk({tag, ".valid"}, req_valid, 1'b1);
    chk({tag, ".tid"},   q_tid,     t);
    chk({tag, ".store"}, q_store,   st);
    chk({tag, ".addr"},  q_addr,    a);
    chk({tag, ".data"},  q_data,    d);
  endtask

  task automatic chk_fill(input string tag, input logic [1:0] t, input logic [31:0] a,
                          input logic err);
    chk({tag, ".valid"}, fill_valid,  1'b1);
    chk({tag, ".thr"},   fill_thread, t);
    chk({tag, ".addr"},  fill_addr,   a);
    chk({tag, ".err"},   fill_error,  err);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", miss_ready, 4'hF);
    chk("rst.req",   req_valid,  1'b0);
    chk("rst.fill",  fill_valid, 1'b0);
    chk("rst.ferr",  fill_error, 1'b0);
    chk("rst.perr",  protocol_err, 1'b0);
    rst = 1'b0;
    tick();

    // Clean miss on thread 2
    set_miss(2'd2, 32'h1040, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("clean.req", 2'd2, 1'b0, 32'h1040, 128'h0);
    chk("clean.ready", miss_ready, 4'b1011);
    tick();
    chk("clean.once", req_valid, 1'b0);
    set_rsp(1'b1, 2'd2, 1'b0, c_beef);
    tick();
    chk_fill("clean.fill", 2'd2, 32'h1040, 1'b0);
    chk("clean.fdata", fill_data, c_beef);
    chk("clean.ready2", miss_ready[2], 1'b1);
    tick();
    chk("clean.fpulse", fill_valid, 1'b0);

    // Dirty miss on thread 0: store, then load, one fill
    set_miss(2'd0, 32'h3100, 1'b1, 32'h3000, c_a5);
    tick();
    chk_req("dirty.st", 2'd0, 1'b1, 32'h3000, c_a5);
    tick();
    chk("dirty.stonce", req_valid, 1'b0);
    set_rsp(1'b1, 2'd0, 1'b0, c_d1);
    tick();
    chk("dirty.nofill", fill_valid, 1'b0);
    chk_req("dirty.ld", 2'd0, 1'b0, 32'h3100, 128'h0);
    tick();
    set_rsp(1'b1, 2'd0, 1'b0, c_d2);
    tick();
    chk_fill("dirty.fill", 2'd0, 32'h3100, 1'b0);
    chk("dirty.fdata", fill_data, c_d2);

    // Store bus error: no load, error fill
    set_miss(2'd1, 32'h5100, 1'b1, 32'h5000, c_d1);
    tick();
    chk_req("wberr.st", 2'd1, 1'b1, 32'h5000, c_d1);
    tick();
    set_rsp(1'b1, 2'd1, 1'b1, c_d2);
    tick();
    chk_fill("wberr.fill", 2'd1, 32'h5100, 1'b1);
    chk("wberr.noreq", req_valid, 1'b0);
    chk("wberr.ready", miss_ready, 4'hF);
    tick();
    chk("wberr.noreq2", req_valid, 1'b0);

    // Load bus error
    set_miss(2'd3, 32'h7000, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("lderr.ld", 2'd3, 1'b0, 32'h7000, 128'h0);
    tick();
    set_rsp(1'b1, 2'd3, 1'b1, c_d1);
    tick();
    chk_fill("lderr.fill", 2'd3, 32'h7000, 1'b1);

    // Filtering: foreign cache id ignored, stray D$ response flagged
    set_miss(2'd2, 32'h2000, 1'b0, 32'h0, 128'h0);
    tick();
    tick();
    set_rsp(1'b0, 2'd2, 1'b0, c_d1);
    tick();
    chk("filt.nofill", fill_valid, 1'b0);
    chk("filt.perr0", protocol_err, 1'b0);
    chk("filt.ready", miss_ready, 4'b1011);
    set_rsp(1'b1, 2'd2, 1'b0, c_d2);
    tick();
    chk_fill("filt.fill", 2'd2, 32'h2000, 1'b0);
    set_rsp(1'b1, 2'd0, 1'b0, c_d1);
    tick();
    chk("filt.perr1", protocol_err, 1'b1);
    chk("filt.strayfill", fill_valid, 1'b0);
    tick();
    chk("filt.sticky", protocol_err, 1'b1);

    // Async reset while threads 1 and 2 wait
    set_miss(2'd1, 32'h1100, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("ar.g1", 2'd1, 1'b0, 32'h1100, 128'h0);
    set_miss(2'd2, 32'h1200, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("ar.g2", 2'd2, 1'b0, 32'h1200, 128'h0);
    tick();
    chk("ar.waiting", miss_ready, 4'b1001);
    #2 rst = 1'b1;
    #1;
    chk("ar.ready", miss_ready, 4'hF);
    chk("ar.perr", protocol_err, 1'b0);
    chk("ar.req", req_valid, 1'b0);
    chk("ar.fill", fill_valid, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk("ar.nofill", fill_valid, 1'b0);
    set_rsp(1'b1, 2'd1, 1'b0, c_d1);
    tick();
    chk("ar.late", protocol_err, 1'b1);
    chk("ar.latefill", fill_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Simultaneous accept + response, two slots requesting at once, pointer = 3
    set_miss(2'd3, 32'h9100, 1'b1, 32'h9000, c_a5);
    tick();
    chk_req("sim.st3", 2'd3, 1'b1, 32'h9000, c_a5);
    tick();
    set_miss(2'd1, 32'h1500, 1'b0, 32'h0, 128'h0);
    set_rsp(1'b1, 2'd3, 1'b0, c_d1);
    tick();
    chk("sim.nofill", fill_valid, 1'b0);
    chk_req("sim.g1", 2'd1, 1'b0, 32'h1500, 128'h0);
    tick();
    chk_req("sim.g3", 2'd3, 1'b0, 32'h9100, 128'h0);
    tick();
    chk("sim.idle", req_valid, 1'b0);
    set_rsp(1'b1, 2'd1, 1'b0, c_d1);
    tick();
    chk_fill("sim.f1", 2'd1, 32'h1500, 1'b0);
    set_rsp(1'b1, 2'd3, 1'b0, c_d2);
    tick();
    chk_fill("sim.f3", 2'd3, 32'h9100, 1'b0);

    // Burst of misses on 0, 1, 3 with pointer at 3
    set_miss(2'd0, 32'hA000, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("rr.g0", 2'd0, 1'b0, 32'hA000, 128'h0);
    set_miss(2'd1, 32'hB000, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("rr.g1", 2'd1, 1'b0, 32'hB000, 128'h0);
    set_miss(2'd3, 32'hD000, 1'b0, 32'h0, 128'h0);
    tick();
    chk_req("rr.g3", 2'd3, 1'b0, 32'hD000, 128'h0);
    tick();
    chk("rr.none", req_valid, 1'b0);
    chk("rr.ready", miss_ready, 4'b0100);
    set_rsp(1'b1, 2'd3, 1'b0, c_d1);
    tick();
    chk_fill("rr.f3", 2'd3, 32'hD000, 1'b0);
    set_rsp(1'b1, 2'd0, 1'b0, c_d2);
    tick();
    chk_fill("rr.f0", 2'd0, 32'hA000, 1'b0);
    set_rsp(1'b1, 2'd1, 1'b0, c_beef);
    tick();
    chk_fill("rr.f1", 2'd1, 32'hB000, 1'b0);
    chk("rr.fdata", fill_data, c_beef);
    chk("rr.perr", protocol_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
